// File: rtl/wb_trap_ctrl_pkg.sv
// Shared definitions for the writeback trap controller.
//   - Machine-mode CSR addresses handled by the trap CSR file
//   - mcause value used for the machine external interrupt
//   - Controller state encoding
package wb_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // Interrupt flag in bit 31, code 11 = machine external interrupt.
  localparam logic [31:0] MCAUSE_IRQ_EXT = 32'h8000_000B;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StRedirect = 2'd1,
    StDrain    = 2'd2
  } state_e;

endpackage

// File: rtl/wb_csr_file.sv
// Machine-mode trap CSR file: mstatus (MIE/MPIE), mtvec, mscratch, mepc, mcause.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_csr_we/windex/wdata  software CSR write (already gated by the controller)
//   i_trap, i_trap_epc,
//   i_trap_cause           trap entry (exception or interrupt)
//   i_mret                 trap return
//   i_csr_rindex           read address
//   o_csr_rdata            combinational read data of registered state
//   o_mtvec_base, o_mepc   redirect targets
//   o_mie                  global machine interrupt enable
module wb_csr_file
  import wb_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_csr_we,
  input  logic [11:0] i_csr_windex,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_trap,
  input  logic [31:0] i_trap_epc,
  input  logic [31:0] i_trap_cause,
  input  logic        i_mret,
  input  logic [11:0] i_csr_rindex,
  output logic [31:0] o_csr_rdata,
  output logic [31:0] o_mtvec_base,
  output logic [31:0] o_mepc,
  output logic        o_mie
);

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] w_mstatus;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC & 32'hFFFF_FFFC;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
    end else begin
      if (i_csr_we) begin
        case (i_csr_windex)
          CSR_MSTATUS: begin
            r_mie  <= i_csr_wdata[3];
            r_mpie <= i_csr_wdata[7];
          end
          CSR_MTVEC:    r_mtvec    <= i_csr_wdata & 32'hFFFF_FFFC;
          CSR_MSCRATCH: r_mscratch <= i_csr_wdata;
          CSR_MEPC:     r_mepc     <= i_csr_wdata & 32'hFFFF_FFFC;
          CSR_MCAUSE:   r_mcause   <= i_csr_wdata;
          default: ;
        endcase
      end
      // Trap side effects come last so they win over a same-cycle software write.
      if (i_trap) begin
        r_mepc   <= i_trap_epc;
        r_mcause <= i_trap_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (i_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

  // MPP is hardwired to machine mode.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};

  always_comb begin
    o_csr_rdata = 32'h0;
    case (i_csr_rindex)
      CSR_MSTATUS:  o_csr_rdata = w_mstatus;
      CSR_MTVEC:    o_csr_rdata = r_mtvec;
      CSR_MSCRATCH: o_csr_rdata = r_mscratch;
      CSR_MEPC:     o_csr_rdata = r_mepc;
      CSR_MCAUSE:   o_csr_rdata = r_mcause;
      default:      o_csr_rdata = 32'h0;
    endcase
  end

  assign o_mtvec_base = {r_mtvec[31:2], 2'b00};
  assign o_mepc       = r_mepc;
  assign o_mie        = r_mie;

endmodule

// File: rtl/wb_trap_ctrl.sv
// Writeback-stage controller: retires GPR/CSR writes, sequences trap entry and
// mret, and issues a one-cycle flush/redirect followed by a write-suppressing drain.
// Ports:
//   i_clk, i_cpurst                    clock, synchronous active-high reset
//   i_wb_*                             registered MEM/WB instruction state
//   i_irq_ext                          level-sensitive machine external interrupt
//   i_csr_rindex / o_csr_rdata         CSR read port (combinational)
//   o_rf_we/o_rf_waddr/o_rf_wdata      register-file write port (combinational)
//   o_redirect / o_redirect_pc         flush pulse and target PC
module wb_trap_ctrl
  import wb_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_cpurst,
  input  logic        i_wb_valid,
  input  logic        i_wb_wr_reg,
  input  logic [4:0]  i_wb_wr_regindex,
  input  logic [31:0] i_wb_wr_wdata,
  input  logic [31:0] i_wb_pc,
  input  logic        i_wb_exp,
  input  logic [3:0]  i_wb_exp_cause,
  input  logic        i_wb_wr_csrreg,
  input  logic [11:0] i_wb_wr_csrindex,
  input  logic [31:0] i_wb_wr_csrwdata,
  input  logic        i_wb_mret,
  input  logic        i_irq_ext,
  input  logic [11:0] i_csr_rindex,
  output logic [31:0] o_csr_rdata,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc
);

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  logic        w_run;
  logic        w_exp;
  logic        w_mret;
  logic        w_irq;
  logic        w_event;
  logic        w_retire;
  logic        w_csr_we;
  logic        w_mie;
  logic [31:0] w_mtvec_base;
  logic [31:0] w_mepc;
  logic [31:0] w_trap_epc;
  logic [31:0] w_trap_cause;
  logic [31:0] w_target;

  // Event decode, priority exception > mret > interrupt; only honoured in RUN.
  assign w_run  = (r_state == StRun);
  assign w_exp  = w_run & i_wb_exp;
  assign w_mret = w_run & i_wb_mret & ~i_wb_exp;
  assign w_irq  = w_run & ~i_wb_exp & ~i_wb_mret & i_irq_ext & w_mie & i_wb_valid;
  assign w_event = w_exp | w_mret | w_irq;

  // An interrupted instruction still retires; exceptions and mret do not.
  assign w_retire = w_run & i_wb_valid & ~i_wb_exp & ~i_wb_mret & ~i_cpurst;
  assign w_csr_we = w_retire & i_wb_wr_csrreg;

  assign o_rf_we    = w_retire & i_wb_wr_reg & (i_wb_wr_regindex != 5'd0);
  assign o_rf_waddr = i_wb_wr_regindex;
  assign o_rf_wdata = i_wb_wr_wdata;

  // Interrupt resumes at the instruction after the one that retired.
  assign w_trap_epc   = w_exp ? (i_wb_pc & 32'hFFFF_FFFC)
                              : ((i_wb_pc + 32'd4) & 32'hFFFF_FFFC);
  assign w_trap_cause = w_exp ? {28'b0, i_wb_exp_cause} : MCAUSE_IRQ_EXT;
  assign w_target     = w_mret ? w_mepc : w_mtvec_base;

  wb_csr_file #(
    .RESET_MTVEC(RESET_MTVEC)
  ) u_csr (
    .i_clk       (i_clk),
    .i_rst       (i_cpurst),
    .i_csr_we    (w_csr_we),
    .i_csr_windex(i_wb_wr_csrindex),
    .i_csr_wdata (i_wb_wr_csrwdata),
    .i_trap      (w_exp | w_irq),
    .i_trap_epc  (w_trap_epc),
    .i_trap_cause(w_trap_cause),
    .i_mret      (w_mret),
    .i_csr_rindex(i_csr_rindex),
    .o_csr_rdata (o_csr_rdata),
    .o_mtvec_base(w_mtvec_base),
    .o_mepc      (w_mepc),
    .o_mie       (w_mie)
  );

  always_ff @(posedge i_clk) begin
    if (i_cpurst) begin
      r_state       <= StRun;
      r_cnt         <= 3'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'h0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_event) begin
            r_state       <= StRedirect;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_target;
          end
        end
        StRedirect: begin
          r_state    <= StDrain;
          r_redirect <= 1'b0;
          r_cnt      <= 3'(DRAIN_CYCLES);
        end
        StDrain: begin
          // Last drain cycle when the count is about to reach zero.
          if (r_cnt <= 3'd1) begin
            r_state <= StRun;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state    <= StRun;
          r_redirect <= 1'b0;
        end
      endcase
    end
  end

  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Directed bench for wb_trap_ctrl with hand-computed expectations.
module tb_wb_trap_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        wb_valid;
  logic        wb_wr_reg;
  logic [4:0]  wb_wr_regindex;
  logic [31:0] wb_wr_wdata;
  logic [31:0] wb_pc;
  logic        wb_exp;
  logic [3:0]  wb_exp_cause;
  logic        wb_wr_csrreg;
  logic [11:0] wb_wr_csrindex;
  logic [31:0] wb_wr_csrwdata;
  logic        wb_mret;
  logic        irq_ext;
  logic [11:0] csr_rindex;
  logic [31:0] csr_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_trap_ctrl #(
    .RESET_MTVEC (32'h0000_0100),
    .DRAIN_CYCLES(2)
  ) dut (
    .i_clk           (clk),
    .i_cpurst        (cpurst),
    .i_wb_valid      (wb_valid),
    .i_wb_wr_reg     (wb_wr_reg),
    .i_wb_wr_regindex(wb_wr_regindex),
    .i_wb_wr_wdata   (wb_wr_wdata),
    .i_wb_pc         (wb_pc),
    .i_wb_exp        (wb_exp),
    .i_wb_exp_cause  (wb_exp_cause),
    .i_wb_wr_csrreg  (wb_wr_csrreg),
    .i_wb_wr_csrindex(wb_wr_csrindex),
    .i_wb_wr_csrwdata(wb_wr_csrwdata),
    .i_wb_mret       (wb_mret),
    .i_irq_ext       (irq_ext),
    .i_csr_rindex    (csr_rindex),
    .o_csr_rdata     (csr_rdata),
    .o_rf_we         (rf_we),
    .o_rf_waddr      (rf_waddr),
    .o_rf_wdata      (rf_wdata),
    .o_redirect      (redirect),
    .o_redirect_pc   (redirect_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid       = 1'b0;
    wb_wr_reg      = 1'b0;
    wb_wr_regindex = 5'd0;
    wb_wr_wdata    = 32'h0;
    wb_pc          = 32'h0;
    wb_exp         = 1'b0;
    wb_exp_cause   = 4'd0;
    wb_wr_csrreg   = 1'b0;
    wb_wr_csrindex = 12'h0;
    wb_wr_csrwdata = 32'h0;
    wb_mret        = 1'b0;
    irq_ext        = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] idx, input logic [31:0] exp);
    csr_rindex = idx;
    #1;
    check_eq(tag, csr_rdata, exp);
  endtask

  task automatic csr_wr(input logic [11:0] idx, input logic [31:0] data);
    idle();
    wb_valid       = 1'b1;
    wb_wr_csrreg   = 1'b1;
    wb_wr_csrindex = idx;
    wb_wr_csrwdata = data;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    csr_rindex = 12'h0;
    cpurst     = 1'b1;
    tick();
    tick();
    // GPR write blocked while in reset.
    wb_valid = 1'b1; wb_wr_reg = 1'b1; wb_wr_regindex = 5'd5; wb_wr_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("rf_we_in_reset", {31'b0, rf_we}, 32'd0);
    tick();
    cpurst = 1'b0;
    idle();
    tick();

    // Reset state.
    check_eq("rst_redirect", {31'b0, redirect}, 32'd0);
    check_eq("rst_redirect_pc", redirect_pc, 32'h0);
    csr_chk("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_chk("rst_mtvec", 12'h305, 32'h0000_0100);
    csr_chk("rst_mepc", 12'h341, 32'h0);
    csr_chk("rst_mcause", 12'h342, 32'h0);
    csr_chk("rst_unimpl", 12'h344, 32'h0);

    // Plain GPR write, then x0.
    wb_valid = 1'b1; wb_wr_reg = 1'b1; wb_wr_regindex = 5'd5; wb_wr_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("gpr_we", {31'b0, rf_we}, 32'd1);
    check_eq("gpr_waddr", {27'b0, rf_waddr}, 32'd5);
    check_eq("gpr_wdata", rf_wdata, 32'hDEAD_BEEF);
    wb_wr_regindex = 5'd0;
    #1;
    check_eq("gpr_x0_we", {31'b0, rf_we}, 32'd0);
    tick();
    idle();

    // mtvec write; read shows old value until the next cycle.
    wb_valid = 1'b1; wb_wr_csrreg = 1'b1; wb_wr_csrindex = 12'h305; wb_wr_csrwdata = 32'h0000_0203;
    csr_chk("mtvec_no_bypass", 12'h305, 32'h0000_0100);
    tick();
    idle();
    csr_chk("mtvec_written", 12'h305, 32'h0000_0200);

    // Exception at pc 0x80, cause 2, with a GPR write that must not happen.
    wb_valid = 1'b1; wb_exp = 1'b1; wb_exp_cause = 4'd2; wb_pc = 32'h80;
    wb_wr_reg = 1'b1; wb_wr_regindex = 5'd7; wb_wr_wdata = 32'h1111_1111;
    #1;
    check_eq("exp_rf_suppressed", {31'b0, rf_we}, 32'd0);
    check_eq("exp_no_early_redirect", {31'b0, redirect}, 32'd0);
    tick();
    idle();
    check_eq("exp_redirect", {31'b0, redirect}, 32'd1);
    check_eq("exp_redirect_pc", redirect_pc, 32'h0000_0200);
    csr_chk("exp_mepc", 12'h341, 32'h80);
    csr_chk("exp_mcause", 12'h342, 32'h2);
    tick();
    check_eq("exp_redirect_pulse", {31'b0, redirect}, 32'd0);
    tick();
    tick();

    // More CSR writes, then enable MIE.
    csr_wr(12'h340, 32'hCAFE_F00D);
    csr_chk("mscratch", 12'h340, 32'hCAFE_F00D);
    csr_wr(12'h341, 32'h0000_0123);
    csr_chk("mepc_align", 12'h341, 32'h0000_0120);
    csr_wr(12'h300, 32'h0000_0008);
    csr_chk("mstatus_mie", 12'h300, 32'h0000_1808);

    // Interrupt: x3 retires, concurrent mcause write is overridden.
    wb_valid = 1'b1; wb_pc = 32'h40; irq_ext = 1'b1;
    wb_wr_reg = 1'b1; wb_wr_regindex = 5'd3; wb_wr_wdata = 32'h0000_1234;
    wb_wr_csrreg = 1'b1; wb_wr_csrindex = 12'h342; wb_wr_csrwdata = 32'h77;
    #1;
    check_eq("irq_rf_we", {31'b0, rf_we}, 32'd1);
    check_eq("irq_rf_waddr", {27'b0, rf_waddr}, 32'd3);
    tick();
    idle();
    wb_valid = 1'b1; wb_wr_reg = 1'b1; wb_wr_regindex = 5'd4;
    check_eq("irq_redirect", {31'b0, redirect}, 32'd1);
    check_eq("irq_redirect_pc", redirect_pc, 32'h0000_0200);
    check_eq("redirect_rf_suppressed", {31'b0, rf_we}, 32'd0);
    csr_chk("irq_mepc", 12'h341, 32'h44);
    csr_chk("irq_mcause", 12'h342, 32'h8000_000B);
    csr_chk("irq_mstatus", 12'h300, 32'h0000_1880);
    tick();
    check_eq("drain_rf_suppressed", {31'b0, rf_we}, 32'd0);
    tick();
    tick();
    idle();

    // mret: returns to mepc, restores MIE; exceptions during drain ignored.
    wb_valid = 1'b1; wb_mret = 1'b1; wb_wr_reg = 1'b1; wb_wr_regindex = 5'd9;
    #1;
    check_eq("mret_rf_suppressed", {31'b0, rf_we}, 32'd0);
    tick();
    idle();
    check_eq("mret_redirect", {31'b0, redirect}, 32'd1);
    check_eq("mret_redirect_pc", redirect_pc, 32'h44);
    csr_chk("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();
    wb_valid = 1'b1; wb_exp = 1'b1; wb_exp_cause = 4'd5; wb_pc = 32'h98;
    tick();
    check_eq("drain_exp_ignored_a", {31'b0, redirect}, 32'd0);
    tick();
    idle();
    check_eq("drain_exp_ignored_b", {31'b0, redirect}, 32'd0);
    csr_chk("drain_mcause_kept", 12'h342, 32'h8000_000B);
    csr_chk("drain_mepc_kept", 12'h341, 32'h44);

    // Exception, mret and interrupt together: exception only.
    wb_valid = 1'b1; wb_exp = 1'b1; wb_exp_cause = 4'd4; wb_mret = 1'b1; irq_ext = 1'b1;
    wb_pc = 32'h60;
    tick();
    idle();
    check_eq("prio_redirect_pc", redirect_pc, 32'h0000_0200);
    csr_chk("prio_mcause", 12'h342, 32'h4);
    csr_chk("prio_mepc", 12'h341, 32'h60);
    csr_chk("prio_mstatus", 12'h300, 32'h0000_1880);
    tick();
    tick();
    tick();

    // Reset while in REDIRECT.
    wb_valid = 1'b1; wb_exp = 1'b1; wb_exp_cause = 4'd1; wb_pc = 32'h20;
    tick();
    idle();
    check_eq("pre_rst_redirect", {31'b0, redirect}, 32'd1);
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    check_eq("rst2_redirect", {31'b0, redirect}, 32'd0);
    check_eq("rst2_redirect_pc", redirect_pc, 32'h0);
    csr_chk("rst2_mtvec", 12'h305, 32'h0000_0100);
    csr_chk("rst2_mepc", 12'h341, 32'h0);
    csr_chk("rst2_mcause", 12'h342, 32'h0);
    csr_chk("rst2_mscratch", 12'h340, 32'h0);
    csr_chk("rst2_mstatus", 12'h300, 32'h0000_1800);
    wb_valid = 1'b1; wb_wr_reg = 1'b1; wb_wr_regindex = 5'd6;
    #1;
    check_eq("rst2_run_rf_we", {31'b0, rf_we}, 32'd1);
    tick();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
